// File: rtl/extremum_scan_engine.sv
// extremum_scan_engine
//   Scans a contiguous array in data memory and reports the maximum or
//   minimum element together with its offset from the base address.
//   The engine shares the DataMem read port with the processor; while busy
//   is high the processor must not issue reads.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           one-cycle request, only looked at in IDLE
//   baseAddr        word address of element 0 (captured at start)
//   length          number of elements (captured at start)
//   findMin         0 = maximum, 1 = minimum (captured at start)
//   signedCmp       1 = two's-complement compare, 0 = unsigned (captured)
//   memAddress      read address to DataMem (0 outside SCAN)
//   MemRead         read strobe, high only in SCAN
//   memReadData     read data, valid the cycle after its address/MemRead
//   busy            high in SCAN and DRAIN
//   done            one-cycle completion pulse
//   extVal          extremum value, held until the next accepted start
//   extIndex        offset of the extremum from baseAddr
//   lenErr          last request had length == 0
//   dbgState        current FSM state (IDLE=0, SCAN=1, DRAIN=2, DONE=3)
//
// Handshake: a request is accepted on the rising edge where start is high
// and the engine is in IDLE; any other start is dropped, never queued.
// Completion is signalled by done for exactly one cycle. On the memory side
// every cycle with MemRead high is one read, and its data is taken from
// memReadData in the following cycle with no stall.
module extremum_scan_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [LEN_W-1:0]  length,
  input  logic              findMin,
  input  logic              signedCmp,
  output logic [ADDR_W-1:0] memAddress,
  output logic              MemRead,
  input  logic [DATA_W-1:0] memReadData,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] extVal,
  output logic [LEN_W-1:0]  extIndex,
  output logic              lenErr,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [LEN_W-1:0]    issue_idx;   // index of the address currently driven
  logic [LEN_W-1:0]    last_idx;    // captured length - 1
  logic [LEN_W-1:0]    elem_idx;    // index of the element on memReadData
  logic                elem_valid;  // memReadData carries an element this cycle
  logic                cap_min;
  logic                cap_signed;
  logic [DATA_W-1:0]   run_val;
  logic [LEN_W-1:0]    run_idx;

  logic                better;
  logic                take;
  logic [DATA_W-1:0]   nxt_val;
  logic [LEN_W-1:0]    nxt_idx;

  assign dbgState = state;

  // Strict comparison so that ties keep the lower index. Element 0 always
  // seeds the running value regardless of what the registers held before.
  always_comb begin
    better = 1'b0;
    if (cap_signed) begin
      if (cap_min) better = $signed(memReadData) < $signed(run_val);
      else         better = $signed(memReadData) > $signed(run_val);
    end else begin
      if (cap_min) better = memReadData < run_val;
      else         better = memReadData > run_val;
    end
    take    = (elem_idx == '0) || better;
    nxt_val = take ? memReadData : run_val;
    nxt_idx = take ? elem_idx : run_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      memAddress <= '0;
      MemRead    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      extVal     <= '0;
      extIndex   <= '0;
      lenErr     <= 1'b0;
      issue_idx  <= '0;
      last_idx   <= '0;
      elem_idx   <= '0;
      elem_valid <= 1'b0;
      cap_min    <= 1'b0;
      cap_signed <= 1'b0;
      run_val    <= '0;
      run_idx    <= '0;
    end else begin
      done       <= 1'b0;
      elem_valid <= 1'b0;
      if (elem_valid) begin
        run_val <= nxt_val;
        run_idx <= nxt_idx;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            cap_min    <= findMin;
            cap_signed <= signedCmp;
            if (length == '0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              extVal   <= '0;
              extIndex <= '0;
              lenErr   <= 1'b1;
            end else begin
              state      <= S_SCAN;
              busy       <= 1'b1;
              MemRead    <= 1'b1;
              memAddress <= baseAddr;
              issue_idx  <= '0;
              last_idx   <= length - LEN_W'(1);
            end
          end
        end
        S_SCAN: begin
          // The address on the bus this cycle returns data next cycle.
          elem_valid <= 1'b1;
          elem_idx   <= issue_idx;
          if (issue_idx == last_idx) begin
            state      <= S_DRAIN;
            MemRead    <= 1'b0;
            memAddress <= '0;
          end else begin
            memAddress <= memAddress + ADDR_W'(1);  // wraps modulo 2^ADDR_W
            issue_idx  <= issue_idx + LEN_W'(1);
          end
        end
        S_DRAIN: begin
          // Final element is on memReadData now; publish the result in one step.
          state    <= S_DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          extVal   <= nxt_val;
          extIndex <= nxt_idx;
          lenErr   <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extremum_scan_engine.sv
// Directed bench for extremum_scan_engine with a behavioural DataMem that
// returns mem[memAddress] one cycle after the address is driven.
module tb_extremum_scan_engine;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int LW = 12;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic [LW-1:0] length = '0;
  logic          findMin = 1'b0;
  logic          signedCmp = 1'b0;
  logic [AW-1:0] memAddress;
  logic          MemRead;
  logic [DW-1:0] memReadData = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] extVal;
  logic [LW-1:0] extIndex;
  logic          lenErr;
  logic [1:0]    dbgState;

  always #5 clk = ~clk;

  extremum_scan_engine #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr),
    .length(length), .findMin(findMin), .signedCmp(signedCmp),
    .memAddress(memAddress), .MemRead(MemRead), .memReadData(memReadData),
    .busy(busy), .done(done), .extVal(extVal), .extIndex(extIndex),
    .lenErr(lenErr), .dbgState(dbgState)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) memReadData <= mem[memAddress];

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic [AW-1:0] exp_q[$];
  int done_cyc, n_done, n_reads, n_busy, n_idle_addr;
  logic [DW-1:0] res_val;
  logic [LW-1:0] res_idx;
  logic          res_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Requests a scan, scrambles the request inputs right after acceptance,
  // optionally pulses start again during cycle `poke`, and checks timing,
  // read addresses and result. Cycle n is the cycle after edge n, edge 0
  // being the accepting edge.
  task automatic do_scan(input logic [AW-1:0] base, input logic [LW-1:0] len,
                         input logic fmin, input logic sgn, input int poke,
                         input logic [DW-1:0] exp_val, input logic [LW-1:0] exp_idx,
                         input logic exp_err);
    int lim;
    int exp_done;
    int exp_busy;
    exp_q.delete();
    for (int k = 0; k < int'(len); k++) exp_q.push_back(base + AW'(k));
    done_cyc = 0; n_done = 0; n_reads = 0; n_busy = 0; n_idle_addr = 0;
    res_val = '0; res_idx = '0; res_err = 1'b0;
    lim      = int'(len) + 8;
    exp_done = (len == 0) ? 1 : int'(len) + 2;
    exp_busy = (len == 0) ? 0 : int'(len) + 1;

    @(negedge clk);
    start = 1'b1; baseAddr = base; length = len; findMin = fmin; signedCmp = sgn;
    @(posedge clk); #1;
    start = 1'b0;
    baseAddr = AW'($urandom); length = LW'($urandom_range(0, 4095));
    findMin = ~fmin; signedCmp = ~sgn;
    for (int c = 1; c <= lim; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (MemRead) begin
        n_reads++;
        if (exp_q.size() > 0) check("read_addr", 32'(memAddress), 32'(exp_q.pop_front()));
        else check("extra_read", n_reads, int'(len));
      end else if (memAddress != '0) begin
        n_idle_addr++;
      end
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = c; res_val = extVal; res_idx = extIndex; res_err = lenErr;
        end
      end
      start = (c == poke);
    end
    start = 1'b0;
    check("done_cycle", done_cyc, exp_done);
    check("done_pulses", n_done, 1);
    check("read_count", n_reads, int'(len));
    check("busy_cycles", n_busy, exp_busy);
    check("idle_addr_nonzero", n_idle_addr, 0);
    check("ext_val", 32'(res_val), 32'(exp_val));
    check("ext_index", 32'(res_idx), 32'(exp_idx));
    check("len_err", 32'(res_err), 32'(exp_err));
    check("ext_val_hold", 32'(extVal), 32'(exp_val));
    check("ext_index_hold", 32'(extIndex), 32'(exp_idx));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_memread", 32'(MemRead), 0);
    check("rst_done", 32'(done), 0);
    check("rst_extval", 32'(extVal), 0);
    check("rst_lenerr", 32'(lenErr), 0);
    @(negedge clk); rst = 1'b0;

    // Unsigned max with a tie; start in the DONE cycle must be ignored.
    mem[0] = 16'd3; mem[1] = 16'd7; mem[2] = 16'd2; mem[3] = 16'd9; mem[4] = 16'd9;
    mem[5] = 16'd1; mem[6] = 16'd0; mem[7] = 16'd4; mem[8] = 16'd5; mem[9] = 16'd8;
    do_scan(12'd0, 12'd10, 1'b0, 1'b0, 12, 16'd9, 12'd3, 1'b0);

    // Signed vs unsigned min over the same data.
    mem[100] = 16'h0005; mem[101] = 16'hFFFE; mem[102] = 16'h7FFF; mem[103] = 16'h0001;
    do_scan(12'd100, 12'd4, 1'b1, 1'b1, 0, 16'hFFFE, 12'd1, 1'b0);
    do_scan(12'd100, 12'd4, 1'b1, 1'b0, 0, 16'h0001, 12'd3, 1'b0);

    // Address wrap past the top of memory.
    mem[12'hFFE] = 16'd1; mem[12'hFFF] = 16'd2; mem[0] = 16'd50; mem[1] = 16'd6;
    do_scan(12'hFFE, 12'd4, 1'b0, 1'b0, 0, 16'd50, 12'd2, 1'b0);

    // Zero length.
    do_scan(12'd0, 12'd0, 1'b0, 1'b0, 0, 16'd0, 12'd0, 1'b1);

    // Start during busy is dropped.
    mem[200] = 16'd10; mem[201] = 16'd20; mem[202] = 16'd30; mem[203] = 16'd20; mem[204] = 16'd5;
    do_scan(12'd200, 12'd5, 1'b0, 1'b0, 3, 16'd30, 12'd2, 1'b0);

    // Reset in cycle 3 of an L=8 scan.
    @(negedge clk);
    start = 1'b1; baseAddr = 12'd500; length = 12'd8; findMin = 1'b0; signedCmp = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_memread", 32'(MemRead), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_extval", 32'(extVal), 0);
    check("mid_rst_memaddr", 32'(memAddress), 0);
    @(negedge clk); rst = 1'b0;
    mem[300] = 16'd42;
    do_scan(12'd300, 12'd1, 1'b0, 1'b0, 0, 16'd42, 12'd0, 1'b0);

    // Signed max with inputs scrambled after acceptance.
    mem[400] = 16'hFFFD; mem[401] = 16'd4; mem[402] = 16'd100;
    mem[403] = 16'd7;    mem[404] = 16'd100; mem[405] = 16'hFFFF;
    do_scan(12'd400, 12'd6, 1'b0, 1'b1, 0, 16'd100, 12'd2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
